// File: rtl/fns_enc_seq.sv
// -----------------------------------------------------------------------------
// fns_enc_seq
//   Sequential greedy encoder for the local adjacent-forbidden FNS
//   (Fibonacci numeral system) CAC link. Converts a DATA_W-bit binary word
//   into an 8-bit FNS codeword. Bit weights and a per-bit enable mask are
//   supplied at runtime. One code bit is resolved per cycle, MSB first.
//   Decoding code_out under the same weights and en_flag returns data_in.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   data_in    binary word to encode (DATA_W bits)
//   en_flag    per-code-bit enable; 0 forces that code bit to 0
//   FNS03..08  weights of code bits 2..7 (FNS_W bits); bits 0 and 1 weigh 1
//   in_valid   data_in/en_flag/weights valid
//   in_ready   encoder idle, can accept a word
//   code_out   codeword, bit i weighted by w_i
//   err        final remainder non-zero (word not representable)
//   out_valid  code_out/err valid
//   out_ready  consumer accepts code_out
// -----------------------------------------------------------------------------
module fns_enc_seq #(
   parameter int DATA_W = 6,
   parameter int FNS_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [7:0]        en_flag,
   input  logic [FNS_W-1:0]  FNS03,
   input  logic [FNS_W-1:0]  FNS04,
   input  logic [FNS_W-1:0]  FNS05,
   input  logic [FNS_W-1:0]  FNS06,
   input  logic [FNS_W-1:0]  FNS07,
   input  logic [FNS_W-1:0]  FNS08,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        code_out,
   output logic              err,
   output logic              out_valid,
   input  logic              out_ready
);

   // Compare/subtract width: remainder and weights are both zero-extended to this.
   localparam int CW = (DATA_W > FNS_W) ? DATA_W : FNS_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        rem_q, rem_d;
   logic [7:0]           en_q, en_d;
   logic [7:0]           code_q, code_d;
   logic [5:0][CW-1:0]   w_q, w_d;      // captured weights of code bits 2..7
   logic [2:0]           idx_q, idx_d;
   logic                 err_q, err_d;

   logic [CW-1:0]        w_cur;
   logic                 bit_cur;

   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      en_d    = en_q;
      code_d  = code_q;
      w_d     = w_q;
      idx_d   = idx_q;
      err_d   = err_q;

      // Bits 0 and 1 have a fixed weight of 1; the rest come from the captured set.
      w_cur   = (idx_q < 3'd2) ? CW'(1) : w_q[idx_q - 3'd2];
      // A zero weight makes the compare true: the bit is set, remainder unchanged.
      bit_cur = en_q[idx_q] && (rem_q >= w_cur);

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               rem_d   = CW'(data_in);
               en_d    = en_flag;
               w_d     = {CW'(FNS08), CW'(FNS07), CW'(FNS06),
                          CW'(FNS05), CW'(FNS04), CW'(FNS03)};
               code_d  = '0;
               err_d   = 1'b0;
               idx_d   = 3'd7;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            code_d[idx_q] = bit_cur;
            // Runs only when rem_q >= w_cur, so it can never underflow.
            if (bit_cur) rem_d = rem_q - w_cur;
            idx_d = idx_q - 3'd1;
            if (idx_q == 3'd0) begin
               err_d   = (rem_d != '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Going back through IDLE means no word is taken on the handshake edge.
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the weight bank is small and cleared on reset like every
         // other register, so nothing powers up undefined.
         state_q <= S_IDLE;
         rem_q   <= '0;
         en_q    <= '0;
         code_q  <= '0;
         w_q     <= '0;
         idx_q   <= 3'd7;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         en_q    <= en_d;
         code_q  <= code_d;
         w_q     <= w_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign code_out  = code_q;
   assign err       = err_q;

endmodule
